spi_master_parallel: RTL

SPI_MASTER_PARALLEL -- requirements
Module: spi_master_parallel

---
 rtl/spi_master_parallel.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_parallel.sv
// Parallel-word SPI-style master (CPOL=0, active-high select) with back-to-back bursts,
// plus a matching parallel slave. Define SPI_MASTER_LOOPBACK_EN to capture o_MOSI instead of i_MISO.
module spi_master_parallel #(
  parameter int NB_BITS = 32,
  parameter int CLK_DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_busy,
  output logic               o_SCLK,
  output logic               o_cs,
  output logic [NB_BITS-1:0] o_MOSI,
  input  logic [NB_BITS-1:0] i_MISO
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;
  logic               w_cnt_last;
  logic               w_accept;
  logic               w_load;
  logic               w_capture;
  logic               w_ready_next;
  logic               r_ready;
  logic               r_cs;
  logic               r_sclk;
  logic               r_busy;
  logic               r_dv;
  logic [NB_BITS-1:0] r_mosi;
  logic [NB_BITS-1:0] r_data;
  logic [NB_BITS-1:0] w_capture_src;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_accept   = i_valid && r_ready;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = ^i_MISO;
  assign w_capture_src = r_mosi;
`else
  assign w_capture_src = i_MISO;
`endif

  // Next-state, half-period counter and load/capture strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = CNT_ZERO;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SETUP;
          w_load       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      SETUP: begin
        if (w_cnt_last) begin
          w_next_state = HIGH;
        end else begin
          w_next_state = SETUP;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (w_cnt_last) begin
          w_next_state = LOW;
        end else begin
          w_next_state = HIGH;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      LOW: begin
        if (w_cnt_last) begin
          w_capture = 1'b1;
          if (w_accept) begin
            w_next_state = SETUP;
            w_load       = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end else begin
          w_next_state = LOW;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      DONE: begin
        if (w_cnt_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    // Ready is registered, so it is predicted from where the FSM lands next cycle.
    w_ready_next = (w_next_state == IDLE) ||
                   ((w_next_state == LOW) && (w_cnt_next == CNT_LAST));
  end

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cs    <= 1'b0;
      r_sclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_dv    <= 1'b0;
      r_mosi  <= {NB_BITS{1'b0}};
      r_data  <= {NB_BITS{1'b0}};
    end else begin
      r_cs    <= (w_next_state != IDLE);
      r_sclk  <= (w_next_state == HIGH);
      r_busy  <= (w_next_state != IDLE);
      r_ready <= w_ready_next;
      r_dv    <= w_capture;
      if (w_load) begin
        r_mosi <= i_data;
      end else begin
        r_mosi <= r_mosi;
      end
      if (w_capture) begin
        r_data <= w_capture_src;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign o_ready      = r_ready;
  assign o_data       = r_data;
  assign o_data_valid = r_dv;
  assign o_busy       = r_busy;
  assign o_SCLK       = r_sclk;
  assign o_cs         = r_cs;
  assign o_MOSI       = r_mosi;

endmodule

// Parallel slave: presents i_data on o_MISO while deselected, captures i_MOSI on SCLK rise.
module spi_slave_parallel #(
  parameter int NB_BITS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_data,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_data_valid,
  input  logic               i_SCLK,
  input  logic               i_cs,
  input  logic [NB_BITS-1:0] i_MOSI,
  output logic [NB_BITS-1:0] o_MISO
);

  logic               r_sclk_d;
  logic               w_sclk_rise;
  logic [NB_BITS-1:0] r_miso;
  logic [NB_BITS-1:0] r_data;
  logic               r_dv;

  assign w_sclk_rise = i_cs && i_SCLK && !r_sclk_d;

  // Edge detect, reply word and receive capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sclk_d <= 1'b0;
      r_miso   <= {NB_BITS{1'b0}};
      r_data   <= {NB_BITS{1'b0}};
      r_dv     <= 1'b0;
    end else begin
      r_sclk_d <= i_SCLK;
      if (!i_cs) begin
        r_miso <= i_data;
      end else begin
        r_miso <= r_miso;
      end
      if (w_sclk_rise) begin
        r_data <= i_MOSI;
        r_dv   <= 1'b1;
      end else begin
        r_data <= r_data;
        r_dv   <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_dv;
  assign o_MISO       = r_miso;

endmodule
